// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - op encodings, state encoding and default latencies for the MDU
package mdu_pkg;

  // E-stage MDU operation codes; 6 and 7 are reserved and behave as no-ops.
  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  localparam int MDU_MUL_CYCLES_DEF = 5;
  localparam int MDU_DIV_CYCLES_DEF = 10;

  // Counter width; latencies up to 255 cycles are representable.
  localparam int MDU_CNT_W = 8;

  // MULT/MULTU/DIV/DIVU occupy codes 0..3, i.e. bit 2 clear.
  function automatic logic is_muldiv(input logic [2:0] op);
    return ~op[2];
  endfunction

  // DIV/DIVU are codes 2 and 3.
  function automatic logic is_div(input logic [2:0] op);
    return ~op[2] & op[1];
  endfunction

endpackage

// File: rtl/mdu.sv
// rtl/mdu.sv - multi-cycle multiply/divide unit holding the HI/LO registers
module mdu
  import mdu_pkg::*;
#(
  parameter int MUL_CYCLES = MDU_MUL_CYCLES_DEF,
  parameter int DIV_CYCLES = MDU_DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [MDU_CNT_W-1:0] MUL_LOAD = MUL_CYCLES[MDU_CNT_W-1:0];
  localparam logic [MDU_CNT_W-1:0] DIV_LOAD = DIV_CYCLES[MDU_CNT_W-1:0];
  localparam logic [MDU_CNT_W-1:0] CNT_ONE  = {{(MDU_CNT_W-1){1'b0}}, 1'b1};

  mdu_state_e           state_q, state_d;
  logic [MDU_CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]           op_q, op_d;
  logic [31:0]          a_q, a_d;
  logic [31:0]          b_q, b_d;
  logic [31:0]          hi_q, hi_d;
  logic [31:0]          lo_q, lo_d;

  logic signed [63:0]   prod_s;
  logic [63:0]          prod_u;
  logic [31:0]          div_b_safe;
  logic signed [32:0]   dvd_s, dvs_s, quo_s, rem_s;
  logic [31:0]          quo_u, rem_u;
  logic [31:0]          res_hi, res_lo;
  logic                 res_wr;
  logic                 unused_div_msbs;

  // Result datapath: evaluated purely from the latched operands so that the
  // forwarded a/b inputs may change freely while the operation is in flight.
  // A zero divisor is replaced by 1 to keep the dividers well defined; the
  // write is suppressed in that case so HI/LO keep their old values.
  always_comb begin
    prod_s     = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    prod_u     = {32'b0, a_q} * {32'b0, b_q};
    div_b_safe = (b_q == 32'd0) ? 32'd1 : b_q;
    // 33-bit signed extension lets 0x8000_0000 / -1 produce +2^31 without
    // overflow; its low 32 bits are the architecturally required 0x8000_0000.
    dvd_s      = $signed({a_q[31], a_q});
    dvs_s      = $signed({div_b_safe[31], div_b_safe});
    quo_s      = dvd_s / dvs_s;
    rem_s      = dvd_s % dvs_s;
    quo_u      = a_q / div_b_safe;
    rem_u      = a_q % div_b_safe;
    res_hi     = hi_q;
    res_lo     = lo_q;
    res_wr     = 1'b0;
    case (op_q)
      MDU_MULT: begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
        res_wr = 1'b1;
      end
      MDU_MULTU: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
        res_wr = 1'b1;
      end
      MDU_DIV: begin
        res_hi = rem_s[31:0];
        res_lo = quo_s[31:0];
        res_wr = (b_q != 32'd0);
      end
      MDU_DIVU: begin
        res_hi = rem_u;
        res_lo = quo_u;
        res_wr = (b_q != 32'd0);
      end
      default: begin
        res_wr = 1'b0;
      end
    endcase
    unused_div_msbs = quo_s[32] ^ rem_s[32];
  end

  // Next-state logic: accept work only when idle, count down while running,
  // and retire the result on the edge where the counter reaches zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (state_q == ST_IDLE) begin
      if (start) begin
        if (is_muldiv(op)) begin
          op_d    = op;
          a_d     = a;
          b_d     = b;
          cnt_d   = is_div(op) ? DIV_LOAD : MUL_LOAD;
          state_d = ST_RUN;
        end else if (op == MDU_MTHI) begin
          hi_d = a;
        end else if (op == MDU_MTLO) begin
          lo_d = a;
        end
      end
    end else begin
      // Any start seen here is dropped; the hazard unit should never send one.
      if (cnt_q <= CNT_ONE) begin
        cnt_d   = '0;
        state_d = ST_IDLE;
        if (res_wr) begin
          hi_d = res_hi;
          lo_d = res_lo;
        end
      end else begin
        cnt_d = cnt_q - CNT_ONE;
      end
    end
  end

  // State and architectural registers; reset clears everything at once,
  // discarding any result still in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// tb/tb_mdu.sv - self-checking bench for mdu against an arithmetic HI/LO model
module tb_mdu;

  localparam int MUL_N = 5;
  localparam int DIV_N = 10;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int          checks;
  int          failures;
  logic [31:0] hi_m;
  logic [31:0] lo_m;

  mdu #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: HI/LO after an instruction, from plain 64-bit arithmetic.
  function automatic void model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint          sx, sy, p, q, r;
    longint unsigned pu;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      3'd0: begin p = sx * sy; hi_m = p[63:32]; lo_m = p[31:0]; end
      3'd1: begin pu = longint'(x) * longint'(y); hi_m = pu[63:32]; lo_m = pu[31:0]; end
      3'd2: if (y != 0) begin q = sx / sy; r = sx % sy; lo_m = q[31:0]; hi_m = r[31:0]; end
      3'd3: if (y != 0) begin lo_m = x / y; hi_m = x % y; end
      3'd4: hi_m = x;
      3'd5: lo_m = x;
      default: ;
    endcase
  endfunction

  function automatic int exp_cycles(input logic [2:0] o);
    if (o <= 3'd1) return MUL_N;
    if (o <= 3'd3) return DIV_N;
    return 0;
  endfunction

  // Issue one instruction and count edges until busy drops (bounded).
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, output int cyc);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    #1;
    start = 1'b0; a = $urandom; b = $urandom;
    cyc = 0;
    while (busy && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    #2;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (hi !== 32'd0) begin failures++; $display("FAIL reset_hi got=%h exp=0", hi); end
    checks++; if (lo !== 32'd0) begin failures++; $display("FAIL reset_lo got=%h exp=0", lo); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL post_reset_busy got=%b exp=0", busy); end
  endtask

  task automatic test_mult();
    int cyc;
    issue(3'd0, 32'hFFFF_FFFD, 32'd7, cyc);
    checks++; if (cyc != MUL_N) begin failures++; $display("FAIL mult_cycles got=%0d exp=%0d", cyc, MUL_N); end
    checks++; if (hi !== 32'hFFFF_FFFF) begin failures++; $display("FAIL mult_hi got=%h exp=ffffffff", hi); end
    checks++; if (lo !== 32'hFFFF_FFEB) begin failures++; $display("FAIL mult_lo got=%h exp=ffffffeb", lo); end
    issue(3'd1, 32'hFFFF_FFFD, 32'd7, cyc);
    checks++; if (cyc != MUL_N) begin failures++; $display("FAIL multu_cycles got=%0d exp=%0d", cyc, MUL_N); end
    checks++; if (hi !== 32'h0000_0006) begin failures++; $display("FAIL multu_hi got=%h exp=00000006", hi); end
    checks++; if (lo !== 32'hFFFF_FFEB) begin failures++; $display("FAIL multu_lo got=%h exp=ffffffeb", lo); end
  endtask

  task automatic test_div();
    int cyc;
    issue(3'd2, 32'hFFFF_FFF9, 32'd2, cyc);
    checks++; if (cyc != DIV_N) begin failures++; $display("FAIL div_cycles got=%0d exp=%0d", cyc, DIV_N); end
    checks++; if (lo !== 32'hFFFF_FFFD) begin failures++; $display("FAIL div_lo got=%h exp=fffffffd", lo); end
    checks++; if (hi !== 32'hFFFF_FFFF) begin failures++; $display("FAIL div_hi got=%h exp=ffffffff", hi); end
    issue(3'd3, 32'd7, 32'd2, cyc);
    checks++; if (lo !== 32'd3) begin failures++; $display("FAIL divu_lo got=%h exp=3", lo); end
    checks++; if (hi !== 32'd1) begin failures++; $display("FAIL divu_hi got=%h exp=1", hi); end
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
    checks++; if (lo !== 32'h8000_0000) begin failures++; $display("FAIL div_ovf_lo got=%h exp=80000000", lo); end
    checks++; if (hi !== 32'd0) begin failures++; $display("FAIL div_ovf_hi got=%h exp=0", hi); end
  endtask

  task automatic test_div_zero();
    int cyc;
    issue(3'd4, 32'h11, 32'd0, cyc);
    issue(3'd5, 32'h22, 32'd0, cyc);
    issue(3'd3, 32'd5, 32'd0, cyc);
    checks++; if (cyc != DIV_N) begin failures++; $display("FAIL divu0_cycles got=%0d exp=%0d", cyc, DIV_N); end
    checks++; if (hi !== 32'h11) begin failures++; $display("FAIL divu0_hi got=%h exp=11", hi); end
    checks++; if (lo !== 32'h22) begin failures++; $display("FAIL divu0_lo got=%h exp=22", lo); end
    issue(3'd2, 32'hFFFF_0000, 32'd0, cyc);
    checks++; if (cyc != DIV_N) begin failures++; $display("FAIL div0_cycles got=%0d exp=%0d", cyc, DIV_N); end
    checks++; if ({hi, lo} !== 64'h11_0000_0022) begin failures++; $display("FAIL div0_hilo got=%h_%h exp=00000011_00000022", hi, lo); end
  endtask

  task automatic test_mthi_mtlo();
    int cyc;
    issue(3'd4, 32'h1234_5678, 32'd0, cyc);
    checks++; if (cyc != 0) begin failures++; $display("FAIL mthi_busy got=%0d exp=0", cyc); end
    checks++; if (hi !== 32'h1234_5678) begin failures++; $display("FAIL mthi_hi got=%h exp=12345678", hi); end
    issue(3'd5, 32'h9ABC_DEF0, 32'd0, cyc);
    checks++; if (lo !== 32'h9ABC_DEF0) begin failures++; $display("FAIL mtlo_lo got=%h exp=9abcdef0", lo); end
    checks++; if (hi !== 32'h1234_5678) begin failures++; $display("FAIL mtlo_hi_kept got=%h exp=12345678", hi); end
    issue(3'd7, 32'hDEAD_BEEF, 32'd1, cyc);
    checks++; if ({hi, lo} !== 64'h1234_5678_9ABC_DEF0 || cyc != 0) begin
      failures++; $display("FAIL reserved_op got=%h_%h cyc=%0d exp=12345678_9abcdef0 cyc=0", hi, lo, cyc);
    end
  endtask

  task automatic test_ignore_while_busy();
    int edges;
    @(negedge clk);
    start = 1'b1; op = 3'd0; a = 32'h0001_0000; b = 32'h0003_0001;
    @(posedge clk);
    @(negedge clk);
    op = 3'd5; a = 32'hDEAD_BEEF;
    @(posedge clk);
    @(negedge clk);
    op = 3'd0; a = 32'd0; b = 32'd0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    edges = 2;
    while (edges < 50) begin
      @(posedge clk); #1;
      edges++;
      if (!busy) break;
    end
    checks++; if (edges != MUL_N) begin failures++; $display("FAIL ignore_cycles got=%0d exp=%0d", edges, MUL_N); end
    checks++; if (hi !== 32'd3) begin failures++; $display("FAIL ignore_hi got=%h exp=3", hi); end
    checks++; if (lo !== 32'h0001_0000) begin failures++; $display("FAIL ignore_lo got=%h exp=00010000", lo); end
  endtask

  task automatic test_operand_change();
    logic [31:0] x, y;
    int          cyc;
    x = $urandom; y = $urandom;
    model(3'd0, x, y);
    @(negedge clk);
    start = 1'b1; op = 3'd0; a = x; b = y;
    @(posedge clk);
    cyc = 0;
    do begin
      @(negedge clk);
      start = 1'b0; a = $urandom; b = $urandom;
      @(posedge clk); #1;
      cyc++;
    end while (busy && cyc < 50);
    checks++; if (cyc != MUL_N) begin failures++; $display("FAIL opchg_cycles got=%0d exp=%0d", cyc, MUL_N); end
    checks++; if ({hi, lo} !== {hi_m, lo_m}) begin failures++; $display("FAIL opchg_hilo got=%h_%h exp=%h_%h", hi, lo, hi_m, lo_m); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] x1, y1, x2, y2, h1, l1;
    int          cyc;
    x1 = $urandom; y1 = $urandom; x2 = $urandom; y2 = $urandom;
    model(3'd0, x1, y1);
    h1 = hi_m; l1 = lo_m;
    @(negedge clk);
    start = 1'b1; op = 3'd0; a = x1; b = y1;
    @(posedge clk);
    @(negedge clk);
    op = 3'd1; a = x2; b = y2;
    for (int k = 1; k < MUL_N; k++) begin
      @(posedge clk); #1;
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_busy_hold k=%0d got=%b exp=1", k, busy); end
    end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_busy_fall got=%b exp=0", busy); end
    checks++; if ({hi, lo} !== {h1, l1}) begin failures++; $display("FAIL b2b_first got=%h_%h exp=%h_%h", hi, lo, h1, l1); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_accept got=%b exp=1", busy); end
    @(negedge clk);
    start = 1'b0;
    model(3'd1, x2, y2);
    cyc = 1;
    while (busy && cyc < 50) begin
      @(posedge clk); #1;
      if (busy) cyc++;
    end
    checks++; if (cyc != MUL_N) begin failures++; $display("FAIL b2b_second_cycles got=%0d exp=%0d", cyc, MUL_N); end
    checks++; if ({hi, lo} !== {hi_m, lo_m}) begin failures++; $display("FAIL b2b_second got=%h_%h exp=%h_%h", hi, lo, hi_m, lo_m); end
  endtask

  task automatic test_random();
    logic [2:0]  o;
    logic [31:0] x, y;
    int          cyc;
    issue(3'd4, 32'hCAFE_0001, 32'd0, cyc);
    model(3'd4, 32'hCAFE_0001, 32'd0);
    issue(3'd5, 32'hCAFE_0002, 32'd0, cyc);
    model(3'd5, 32'hCAFE_0002, 32'd0);
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 7));
      x = $urandom; y = $urandom;
      if ($urandom_range(0, 7) == 0) y = 32'd0;
      if ($urandom_range(0, 15) == 0) begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
      if ($urandom_range(0, 7) == 0) y = 32'($urandom_range(1, 9));
      issue(o, x, y, cyc);
      model(o, x, y);
      checks++; if (cyc != exp_cycles(o)) begin failures++; $display("FAIL rand_cycles i=%0d op=%0d got=%0d exp=%0d", i, o, cyc, exp_cycles(o)); end
      checks++; if ({hi, lo} !== {hi_m, lo_m}) begin
        failures++; $display("FAIL rand_hilo i=%0d op=%0d a=%h b=%h got=%h_%h exp=%h_%h", i, o, x, y, hi, lo, hi_m, lo_m);
      end
    end
  endtask

  task automatic test_async_reset();
    int cyc;
    issue(3'd4, 32'hAAAA_5555, 32'd0, cyc);
    issue(3'd5, 32'h5555_AAAA, 32'd0, cyc);
    @(negedge clk);
    start = 1'b1; op = 3'd0; a = 32'd7; b = 32'd9;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL areset_busy got=%b exp=0", busy); end
    checks++; if (hi !== 32'd0) begin failures++; $display("FAIL areset_hi got=%h exp=0", hi); end
    checks++; if (lo !== 32'd0) begin failures++; $display("FAIL areset_lo got=%h exp=0", lo); end
    #3;
    reset = 1'b0;
    repeat (MUL_N + 3) @(posedge clk);
    #1;
    checks++; if ({busy, hi, lo} !== 65'd0) begin failures++; $display("FAIL areset_late got=%b_%h_%h exp=0_0_0", busy, hi, lo); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    hi_m     = 32'd0;
    lo_m     = 32'd0;
    reset    = 1'b1;
    start    = 1'b0;
    op       = 3'd0;
    a        = 32'd0;
    b        = 32'd0;
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_mthi_mtlo();
    test_ignore_while_busy();
    test_operand_change();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
